// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control sequencer.
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_ctl_e;
   typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10} imm_src_e;
   typedef enum logic [2:0] {CLS_ILL, CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ} instr_cls_e;
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB} state_e;

   typedef struct packed {
      instr_cls_e cls;
      alu_ctl_e   alu_ctl;
      logic       alu_src;
      imm_src_e   imm_src;
      logic       result_src;
      logic       illegal;
   } dec_t;
endpackage

// File: rtl/riscv_main_decoder.sv
// Combinational classification of the latched instruction into static controls.
module riscv_main_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   output dec_t       o_dec
);
   always_comb begin
      // Unsupported encodings leave every static control at zero.
      o_dec = '0;
      case (i_opcode)
         OP_R: begin
            case ({i_funct7, i_funct3})
               10'b0000000_000: begin o_dec.cls = CLS_ALU; o_dec.alu_ctl = ALU_ADD; end
               10'b0100000_000: begin o_dec.cls = CLS_ALU; o_dec.alu_ctl = ALU_SUB; end
               10'b0000000_110: begin o_dec.cls = CLS_ALU; o_dec.alu_ctl = ALU_OR;  end
               10'b0000000_111: begin o_dec.cls = CLS_ALU; o_dec.alu_ctl = ALU_AND; end
               default: ;
            endcase
         end
         OP_I: begin
            case (i_funct3)
               3'b000: begin o_dec.cls = CLS_ALU; o_dec.alu_src = 1'b1; o_dec.alu_ctl = ALU_ADD; end
               3'b110: begin o_dec.cls = CLS_ALU; o_dec.alu_src = 1'b1; o_dec.alu_ctl = ALU_OR;  end
               3'b111: begin o_dec.cls = CLS_ALU; o_dec.alu_src = 1'b1; o_dec.alu_ctl = ALU_AND; end
               default: ;
            endcase
         end
         OP_LW: if (i_funct3 == 3'b010) begin
            o_dec.cls        = CLS_LW;
            o_dec.alu_src    = 1'b1;
            o_dec.imm_src    = IMM_I;
            o_dec.result_src = 1'b1;
         end
         OP_SW: if (i_funct3 == 3'b010) begin
            o_dec.cls     = CLS_SW;
            o_dec.alu_src = 1'b1;
            o_dec.imm_src = IMM_S;
         end
         OP_BEQ: if (i_funct3 == 3'b000) begin
            o_dec.cls     = CLS_BEQ;
            o_dec.alu_ctl = ALU_SUB;
            o_dec.imm_src = IMM_B;
         end
         default: ;
      endcase
      o_dec.illegal = (o_dec.cls == CLS_ILL);
   end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM: latches one instruction, then sequences decode/exec/mem/wb strobes.
module riscv_multicycle_ctrl
   import riscv_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_instr_valid,
   input  logic [31:0] i_instr,
   input  logic        i_zero,
   output logic        o_instr_ready,
   output logic [31:0] o_ir,
   output logic        o_PCSrc,
   output logic        o_ResultSrc,
   output logic        o_MemWrite,
   output logic        o_ALUSrc,
   output logic        o_RegWrite,
   output logic [1:0]  o_ALUControl,
   output logic [1:0]  o_ImmSrc,
   output logic        o_pc_en,
   output logic        o_illegal
);
   state_e      r_state, w_state_nxt;
   logic [31:0] r_ir;
   dec_t        w_dec;

   riscv_main_decoder u_dec (
      .i_opcode (r_ir[6:0]),
      .i_funct3 (r_ir[14:12]),
      .i_funct7 (r_ir[31:25]),
      .o_dec    (w_dec)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_FETCH;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_FETCH && i_instr_valid) r_ir <= i_instr;
      end
   end

   // Static controls follow the IR, which only changes on accept.
   assign o_ir         = r_ir;
   assign o_ALUSrc     = w_dec.alu_src;
   assign o_ALUControl = w_dec.alu_ctl;
   assign o_ImmSrc     = w_dec.imm_src;
   assign o_ResultSrc  = w_dec.result_src;

   always_comb begin
      w_state_nxt   = r_state;
      o_instr_ready = 1'b0;
      o_PCSrc       = 1'b0;
      o_MemWrite    = 1'b0;
      o_RegWrite    = 1'b0;
      o_pc_en       = 1'b0;
      o_illegal     = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_instr_ready = 1'b1;
            if (i_instr_valid) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (w_dec.illegal) begin
               o_illegal   = 1'b1;
               o_pc_en     = 1'b1;
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            case (w_dec.cls)
               CLS_ALU: w_state_nxt = S_WB;
               CLS_LW:  w_state_nxt = S_MEMRD;
               CLS_SW:  w_state_nxt = S_MEMWR;
               CLS_BEQ: begin
                  o_PCSrc     = i_zero;
                  o_pc_en     = 1'b1;
                  w_state_nxt = S_FETCH;
               end
               default: w_state_nxt = S_FETCH;
            endcase
         end
         S_MEMRD: w_state_nxt = S_WB;
         S_MEMWR: begin
            o_MemWrite  = 1'b1;
            o_pc_en     = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_WB: begin
            o_RegWrite  = 1'b1;
            o_pc_en     = 1'b1;
            w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench: expected retire-cycle controls queued at issue, checked at each pc_en pulse.
module tb_riscv_multicycle_ctrl;
   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_instr_valid = 1'b0, i_zero = 1'b0;
   logic [31:0] i_instr = '0;
   logic        o_instr_ready, o_PCSrc, o_ResultSrc, o_MemWrite, o_ALUSrc, o_RegWrite, o_pc_en, o_illegal;
   logic [31:0] o_ir;
   logic [1:0]  o_ALUControl, o_ImmSrc;

   riscv_multicycle_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr_valid(i_instr_valid), .i_instr(i_instr),
      .i_zero(i_zero), .o_instr_ready(o_instr_ready), .o_ir(o_ir), .o_PCSrc(o_PCSrc),
      .o_ResultSrc(o_ResultSrc), .o_MemWrite(o_MemWrite), .o_ALUSrc(o_ALUSrc),
      .o_RegWrite(o_RegWrite), .o_ALUControl(o_ALUControl), .o_ImmSrc(o_ImmSrc),
      .o_pc_en(o_pc_en), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic pcsrc, rsrc, mw, rw, asrc;
      logic [1:0] actl, imm;
      logic ill;
      logic [3:0] lat;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;

   function automatic exp_t mk(input logic pcsrc, rsrc, mw, rw, asrc, input logic [1:0] actl, imm,
                               input logic ill, input logic [3:0] lat);
      exp_t e;
      e.pcsrc = pcsrc; e.rsrc = rsrc; e.mw = mw; e.rw = rw; e.asrc = asrc;
      e.actl = actl; e.imm = imm; e.ill = ill; e.lat = lat;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Cycles since the accepting edge; reads pre-edge handshake values.
   always @(posedge i_clk) begin
      if (o_instr_ready && i_instr_valid) cyc = 1;
      else cyc++;
   end

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (o_pc_en) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_pc_en: got pc_en=1 expected no retire at %0t", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("PCSrc", o_PCSrc, e.pcsrc);
               chk("ResultSrc", o_ResultSrc, e.rsrc);
               chk("MemWrite", o_MemWrite, e.mw);
               chk("RegWrite", o_RegWrite, e.rw);
               chk("ALUSrc", o_ALUSrc, e.asrc);
               chk("ALUControl", o_ALUControl, e.actl);
               chk("ImmSrc", o_ImmSrc, e.imm);
               chk("illegal", o_illegal, e.ill);
               chk("latency", cyc, e.lat);
            end
         end else begin
            chk("strobe_idle", {o_MemWrite, o_RegWrite, o_illegal, o_PCSrc}, 0);
         end
      end
   end

   task automatic issue(input logic [31:0] w, input logic z, input exp_t e, input bit push);
      int n = 0;
      @(negedge i_clk);
      while (!o_instr_ready && n < 50) begin @(negedge i_clk); n++; end
      chk("ready_timeout", o_instr_ready, 1);
      #1;
      i_instr = w; i_zero = z; i_instr_valid = 1'b1;
      if (push) q.push_back(e);
      @(posedge i_clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin @(posedge i_clk); n++; end
      @(posedge i_clk); #1;
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ready"}, o_instr_ready, 1);
      chk({name, "_strobes"}, {o_MemWrite, o_RegWrite, o_pc_en, o_illegal, o_PCSrc}, 0);
   endtask

   localparam exp_t E_ILL = '{pcsrc:0, rsrc:0, mw:0, rw:0, asrc:0, actl:0, imm:0, ill:1, lat:1};

   initial begin
      #3;
      chk_quiet("reset");
      chk("reset_ir", o_ir, 0);
      chk("reset_static", {o_ALUSrc, o_ALUControl, o_ImmSrc, o_ResultSrc}, 0);
      @(negedge i_clk); i_rst_n = 1'b1;

      // Back-to-back: valid stays high between words.
      issue(32'h402081B3, 0, mk(0,0,0,1,0,2'b01,2'b00,0,3), 1);
      issue(32'h00802283, 0, mk(0,1,0,1,1,2'b00,2'b00,0,4), 1);
      issue(32'h00502623, 0, mk(0,0,1,0,1,2'b00,2'b01,0,3), 1);
      issue(32'h00208463, 1, mk(1,0,0,0,0,2'b01,2'b10,0,2), 1);
      issue(32'h00208463, 0, mk(0,0,0,0,0,2'b01,2'b10,0,2), 1);
      issue(32'h00000000, 1, E_ILL, 1);
      issue(32'h0020E1B3, 1, mk(0,0,0,1,0,2'b11,2'b00,0,3), 1);
      issue(32'h4020E1B3, 0, E_ILL, 1);
      issue(32'h0020F1B3, 0, mk(0,0,0,1,0,2'b10,2'b00,0,3), 1);
      issue(32'h00500093, 0, mk(0,0,0,1,1,2'b00,2'b00,0,3), 1);
      issue(32'h0050E093, 0, mk(0,0,0,1,1,2'b11,2'b00,0,3), 1);
      i_instr_valid = 1'b0;
      drain();

      // Abort add mid-WB with an asynchronous reset.
      issue(32'h002081B3, 0, mk(0,0,0,1,0,2'b00,2'b00,0,3), 0);
      i_instr_valid = 1'b0;
      @(posedge i_clk); @(posedge i_clk); #1;
      chk("wb_regwrite", {o_RegWrite, o_pc_en}, 2'b11);
      i_rst_n = 1'b0; #1;
      chk_quiet("abort");
      chk("abort_ir", o_ir, 0);
      @(negedge i_clk); @(negedge i_clk); i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      chk_quiet("post_reset");

      issue(32'h002081B3, 0, mk(0,0,0,1,0,2'b00,2'b00,0,3), 1);
      i_instr_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by 200000");
      $fatal(1, "timeout");
   end
endmodule
